// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the architectural PC and issues fetch requests.
// It selects PC+4 or a branch target on each accepted fetch, and keeps debug counters.
module pc_sequencer #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_out,
  input  logic [XLEN-1:0] imm_offset,
  input  logic            halt_req,
  input  logic            if_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            if_valid,
  output logic            misalign_trap,
  output logic [15:0]     taken_count,
  output logic [31:0]     retired_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT, TRAP} state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic                   trap_q, trap_d;
  logic [15:0]            taken_q, taken_d;
  logic [31:0]            retired_q, retired_d;

  logic                   hs;
  logic signed [XLEN-1:0] target_s;
  logic                   misaligned;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign hs         = (state_q == FETCH) && if_ready;
  assign target_s   = $signed(pc_q) + $signed(imm_offset);
  assign misaligned = branch_out && (target_s[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      trap_q    <= 1'b0;
      taken_q   <= 16'd0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_q    <= trap_d;
      taken_q   <= taken_d;
      retired_q <= retired_d;
    end
  end

  // A misaligned target outranks a simultaneous halt request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (hs && misaligned) state_d = TRAP;
        else if (halt_req)    state_d = HALT;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    trap_d    = trap_q;
    taken_d   = taken_q;
    retired_d = retired_q;
    if (hs) begin
      retired_d = retired_q + 32'd1;
      if (!branch_out) begin
        pc_d = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
      end else if (!misaligned) begin
        pc_d    = $unsigned(target_s);
        taken_d = sat_inc16(taken_q);
      end else begin
        trap_d = 1'b1;
      end
    end
  end

  always_comb begin
    if_valid      = (state_q == FETCH);
    pc_out        = pc_q;
    misalign_trap = trap_q;
    taken_count   = taken_q;
    retired_count = retired_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: startup, branches, trap, halt, wrap and saturation.
// A second instance with a near-top RESET_PC covers the sequential wrap to zero.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_out;
  logic [63:0] imm_offset;
  logic        halt_req;
  logic        if_ready;

  logic [63:0] pc_out,   pc_out2;
  logic        if_valid, if_valid2;
  logic        misalign_trap, misalign_trap2;
  logic [15:0] taken_count, taken_count2;
  logic [31:0] retired_count, retired_count2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .branch_out(branch_out), .imm_offset(imm_offset),
    .halt_req(halt_req), .if_ready(if_ready), .pc_out(pc_out), .if_valid(if_valid),
    .misalign_trap(misalign_trap), .taken_count(taken_count), .retired_count(retired_count)
  );

  pc_sequencer #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .branch_out(branch_out), .imm_offset(imm_offset),
    .halt_req(halt_req), .if_ready(if_ready), .pc_out(pc_out2), .if_valid(if_valid2),
    .misalign_trap(misalign_trap2), .taken_count(taken_count2), .retired_count(retired_count2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges, then leave the DUT in FETCH at RESET_PC with if_ready low.
  task automatic start_fetch();
    reset = 1'b1; branch_out = 1'b0; imm_offset = 64'd0; halt_req = 1'b0; if_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; branch_out = 1'b1; imm_offset = 64'd8; halt_req = 1'b1; if_ready = 1'b1;
    step(); step();
    n_vec++; if (if_valid !== 1'b0) begin $display("FAIL reset_valid got %0b want 0", if_valid); n_err++; end
    n_vec++; if (pc_out !== 64'h0) begin $display("FAIL reset_pc got %h want 0", pc_out); n_err++; end
    n_vec++; if ({misalign_trap, taken_count, retired_count} !== 49'd0) begin
      $display("FAIL reset_flags trap=%0b taken=%0d retired=%0d want 0", misalign_trap, taken_count, retired_count); n_err++; end
    reset = 1'b0; branch_out = 1'b0; halt_req = 1'b0; if_ready = 1'b0;
    step();
    n_vec++; if (if_valid !== 1'b1) begin $display("FAIL first_valid got %0b want 1", if_valid); n_err++; end
    n_vec++; if (pc_out !== 64'h0) begin $display("FAIL first_pc got %h want 0", pc_out); n_err++; end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc;
    if_ready = 1'b1; branch_out = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_pc = 64'(i * 4);
      n_vec++; if (pc_out !== exp_pc) begin $display("FAIL seq_pc[%0d] got %h want %h", i, pc_out, exp_pc); n_err++; end
    end
    n_vec++; if (retired_count !== 32'd3) begin $display("FAIL seq_retired got %0d want 3", retired_count); n_err++; end
    step();
    n_vec++; if (pc_out !== 64'h10) begin $display("FAIL seq_pc_10 got %h want 10", pc_out); n_err++; end
  endtask

  task automatic test_taken_branch();
    branch_out = 1'b1; imm_offset = 64'hFFFF_FFFF_FFFF_FFF8; if_ready = 1'b1;
    step();
    n_vec++; if (pc_out !== 64'h08) begin $display("FAIL br_pc got %h want 08", pc_out); n_err++; end
    n_vec++; if (taken_count !== 16'd1) begin $display("FAIL br_taken got %0d want 1", taken_count); n_err++; end
    n_vec++; if (retired_count !== 32'd5) begin $display("FAIL br_retired got %0d want 5", retired_count); n_err++; end
    if_ready = 1'b0;
    step(); step();
    n_vec++; if (pc_out !== 64'h08) begin $display("FAIL stall_pc got %h want 08", pc_out); n_err++; end
    n_vec++; if (taken_count !== 16'd1 || retired_count !== 32'd5) begin
      $display("FAIL stall_counts taken=%0d retired=%0d want 1/5", taken_count, retired_count); n_err++; end
    n_vec++; if (if_valid !== 1'b1) begin $display("FAIL stall_valid got %0b want 1", if_valid); n_err++; end
  endtask

  task automatic test_misalign();
    imm_offset = 64'h18; if_ready = 1'b1;
    step();
    n_vec++; if (pc_out !== 64'h20 || taken_count !== 16'd2) begin
      $display("FAIL pre_trap pc=%h taken=%0d want 20/2", pc_out, taken_count); n_err++; end
    imm_offset = 64'h6;
    step();
    n_vec++; if (misalign_trap !== 1'b1) begin $display("FAIL trap_flag got %0b want 1", misalign_trap); n_err++; end
    n_vec++; if (if_valid !== 1'b0) begin $display("FAIL trap_valid got %0b want 0", if_valid); n_err++; end
    n_vec++; if (pc_out !== 64'h20 || taken_count !== 16'd2 || retired_count !== 32'd7) begin
      $display("FAIL trap_regs pc=%h taken=%0d retired=%0d want 20/2/7", pc_out, taken_count, retired_count); n_err++; end
    branch_out = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_vec++; if (misalign_trap !== 1'b1 || if_valid !== 1'b0 || pc_out !== 64'h20 || retired_count !== 32'd7) begin
      $display("FAIL trap_hold trap=%0b valid=%0b pc=%h retired=%0d want 1/0/20/7", misalign_trap, if_valid, pc_out, retired_count); n_err++; end
    reset = 1'b1;
    step();
    n_vec++; if (misalign_trap !== 1'b0 || pc_out !== 64'h0 || taken_count !== 16'd0 || retired_count !== 32'd0) begin
      $display("FAIL trap_clear trap=%0b pc=%h taken=%0d retired=%0d want 0/0/0/0", misalign_trap, pc_out, taken_count, retired_count); n_err++; end
    reset = 1'b0;
  endtask

  task automatic test_halt();
    start_fetch();
    if_ready = 1'b1;
    step();
    n_vec++; if (pc_out !== 64'h4) begin $display("FAIL halt_pre_pc got %h want 4", pc_out); n_err++; end
    halt_req = 1'b1;
    step();
    n_vec++; if (pc_out !== 64'h8 || if_valid !== 1'b0 || retired_count !== 32'd2) begin
      $display("FAIL halt_hs pc=%h valid=%0b retired=%0d want 8/0/2", pc_out, if_valid, retired_count); n_err++; end
    halt_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_vec++; if (pc_out !== 64'h8 || if_valid !== 1'b0 || retired_count !== 32'd2) begin
      $display("FAIL halt_hold pc=%h valid=%0b retired=%0d want 8/0/2", pc_out, if_valid, retired_count); n_err++; end

    start_fetch();
    if_ready = 1'b1;
    step();
    if_ready = 1'b0; halt_req = 1'b1;
    step();
    n_vec++; if (pc_out !== 64'h4 || if_valid !== 1'b0 || retired_count !== 32'd1) begin
      $display("FAIL halt_stall pc=%h valid=%0b retired=%0d want 4/0/1", pc_out, if_valid, retired_count); n_err++; end
    halt_req = 1'b0; if_ready = 1'b1;
    step(); step();
    n_vec++; if (pc_out !== 64'h4 || if_valid !== 1'b0 || retired_count !== 32'd1) begin
      $display("FAIL halt_stall_hold pc=%h valid=%0b retired=%0d want 4/0/1", pc_out, if_valid, retired_count); n_err++; end

    start_fetch();
    if_ready = 1'b1; halt_req = 1'b1; branch_out = 1'b1; imm_offset = 64'h2;
    step();
    n_vec++; if (misalign_trap !== 1'b1 || pc_out !== 64'h0 || if_valid !== 1'b0) begin
      $display("FAIL trap_over_halt trap=%0b pc=%h valid=%0b want 1/0/0", misalign_trap, pc_out, if_valid); n_err++; end
    halt_req = 1'b0; branch_out = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    start_fetch();
    if_ready = 1'b1;
    step(); step();
    if_ready = 1'b1; branch_out = 1'b1; imm_offset = 64'h40; reset = 1'b1;
    step();
    n_vec++; if (pc_out !== 64'h0 || taken_count !== 16'd0 || retired_count !== 32'd0 || if_valid !== 1'b0) begin
      $display("FAIL reset_mid pc=%h taken=%0d retired=%0d valid=%0b want 0/0/0/0", pc_out, taken_count, retired_count, if_valid); n_err++; end
    reset = 1'b0; branch_out = 1'b0;
  endtask

  task automatic test_wrap();
    start_fetch();
    n_vec++; if (pc_out2 !== 64'hFFFF_FFFF_FFFF_FFFC || if_valid2 !== 1'b1) begin
      $display("FAIL wrap_start pc=%h valid=%0b want fffffffffffffffc/1", pc_out2, if_valid2); n_err++; end
    if_ready = 1'b1;
    step();
    n_vec++; if (pc_out2 !== 64'h0 || retired_count2 !== 32'd1) begin
      $display("FAIL wrap_pc pc=%h retired=%0d want 0/1", pc_out2, retired_count2); n_err++; end
  endtask

  task automatic test_saturation();
    start_fetch();
    if_ready = 1'b1; branch_out = 1'b1; imm_offset = 64'h4;
    for (int i = 0; i < 65535; i++) step();
    n_vec++; if (taken_count !== 16'hFFFF) begin $display("FAIL sat_reach got %h want ffff", taken_count); n_err++; end
    for (int i = 0; i < 5; i++) step();
    n_vec++; if (taken_count !== 16'hFFFF) begin $display("FAIL sat_hold got %h want ffff", taken_count); n_err++; end
    n_vec++; if (retired_count !== 32'd65540 || pc_out !== 64'h40010) begin
      $display("FAIL sat_retired retired=%0d pc=%h want 65540/40010", retired_count, pc_out); n_err++; end
    branch_out = 1'b0; if_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_taken_branch();
    test_misalign();
    test_halt();
    test_reset_mid_stall();
    test_wrap();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
